// File: rtl/conv_layer_param.sv
// Streaming KxK convolution: K-row line buffer, sequential per-tap MAC with all channels in parallel.
// Define CONV_RELU_EN to clamp each registered channel result at zero (ReLU); default presents raw accumulators.
module conv_layer_param #(
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int DATA_BITS   = 8,
  parameter int WEIGHT_BITS = 8,
  parameter int FILTER_SIZE = 7,
  parameter int STRIDE      = 1,
  parameter int NUM_CH      = 3,
  parameter int ACC_BITS    = DATA_BITS + WEIGHT_BITS + $clog2(FILTER_SIZE * FILTER_SIZE) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          w_load,
  input  logic signed [WEIGHT_BITS-1:0] w_data,
  output logic [NUM_CH*ACC_BITS-1:0]    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int K    = FILTER_SIZE;
  localparam int TAPS = K * K;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int RW   = $clog2(HEIGHT + 1);
  localparam int CIW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW   = (K > 1) ? $clog2(K) : 1;
  localparam int SW1  = SW + 1;
  localparam int TW   = $clog2(TAPS + 1);
  localparam int WPW  = (NUM_CH * TAPS > 1) ? $clog2(NUM_CH * TAPS) : 1;
  localparam int PW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int PB   = DATA_BITS + 1 + WEIGHT_BITS;

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  // Handshakes: a pixel transfers on an edge where in_valid && in_ready; a result
  // transfers on an edge where out_valid && out_ready, and out_data is held until then.

  logic [1:0]     state;
  logic [CW-1:0]  col, win_col, rd_col;
  logic [RW-1:0]  row;
  logic [SW-1:0]  slot, win_slot, rd_slot, tap_r, tap_c;
  logic [SW1-1:0] slot_sum;
  logic [PW-1:0]  row_ph, col_ph;
  logic [TW-1:0]  tap_cnt, tap_sel;
  logic [WPW-1:0] w_ptr;
  logic           last_win, trig, last_pix, in_fire;
  logic [DATA_BITS-1:0] pix;

  logic [DATA_BITS-1:0]          line_buf [K][WIDTH];
  logic signed [WEIGHT_BITS-1:0] w_mem [NUM_CH*TAPS];
  logic signed [ACC_BITS-1:0]    acc [NUM_CH];
  logic signed [PB-1:0]          prod [NUM_CH];

  function automatic logic [PW-1:0] ph_inc(input logic [PW-1:0] p);
    return (p == PW'(STRIDE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = (state == ST_ACCEPT);
  assign in_fire  = in_valid && (state == ST_ACCEPT);
  assign last_pix = (row == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));
  // Phase counters track (r-K+1)%STRIDE and (c-K+1)%STRIDE without dividers.
  assign trig     = (row >= RW'(K - 1)) && (col >= CW'(K - 1)) &&
                    (row_ph == '0) && (col_ph == '0);

  always_comb begin
    slot_sum = {1'b0, win_slot} + {1'b0, tap_r};
    rd_slot  = (slot_sum >= SW1'(K)) ? SW'(slot_sum - SW1'(K)) : SW'(slot_sum);
    rd_col   = win_col + CW'(tap_c);
    tap_sel  = (tap_cnt < TW'(TAPS)) ? tap_cnt : '0;
    pix      = line_buf[rd_slot][rd_col[CIW-1:0]];
    for (int ch = 0; ch < NUM_CH; ch++) begin
      prod[ch] = PB'($signed({1'b0, pix})) * PB'(w_mem[WPW'(ch * TAPS) + WPW'(tap_sel)]);
    end
  end

  // Storage arrays are deliberately unreset so weights survive a reset.
  always_ff @(posedge clk) begin
    if (w_load && !busy) w_mem[w_ptr] <= w_data;
    if (in_fire) line_buf[slot][col[CIW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ACCEPT;
      row        <= '0;
      col        <= '0;
      slot       <= '0;
      row_ph     <= '0;
      col_ph     <= '0;
      win_slot   <= '0;
      win_col    <= '0;
      tap_cnt    <= '0;
      tap_r      <= '0;
      tap_c      <= '0;
      w_ptr      <= '0;
      last_win   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) acc[ch] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (w_load && !busy)
        w_ptr <= (w_ptr == WPW'(NUM_CH * TAPS - 1)) ? '0 : w_ptr + 1'b1;

      case (state)
        ST_ACCEPT: begin
          if (in_valid) begin
            if (last_pix && !trig) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              busy <= 1'b1;
            end
            if (trig) begin
              state    <= ST_CALC;
              win_slot <= (slot == SW'(K - 1)) ? '0 : slot + 1'b1;
              win_col  <= col - CW'(K - 1);
              tap_cnt  <= '0;
              tap_r    <= '0;
              tap_c    <= '0;
              last_win <= last_pix;
              for (int ch = 0; ch < NUM_CH; ch++) acc[ch] <= '0;
            end
            if (last_pix) begin
              row    <= '0;
              col    <= '0;
              slot   <= '0;
              row_ph <= '0;
              col_ph <= '0;
            end else if (col == CW'(WIDTH - 1)) begin
              col    <= '0;
              col_ph <= '0;
              row    <= row + 1'b1;
              slot   <= (slot == SW'(K - 1)) ? '0 : slot + 1'b1;
              row_ph <= (row >= RW'(K - 1)) ? ph_inc(row_ph) : '0;
            end else begin
              col    <= col + 1'b1;
              col_ph <= (col >= CW'(K - 1)) ? ph_inc(col_ph) : '0;
            end
          end
        end

        ST_CALC: begin
          if (tap_cnt == TW'(TAPS)) begin
            state     <= ST_OUT;
            out_valid <= 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef CONV_RELU_EN
              out_data[ch*ACC_BITS +: ACC_BITS] <= acc[ch][ACC_BITS-1] ? '0 : acc[ch];
`else
              out_data[ch*ACC_BITS +: ACC_BITS] <= acc[ch];
`endif
            end
          end else begin
            for (int ch = 0; ch < NUM_CH; ch++) acc[ch] <= acc[ch] + ACC_BITS'(prod[ch]);
            tap_cnt <= tap_cnt + 1'b1;
            if (tap_c == SW'(K - 1)) begin
              tap_c <= '0;
              tap_r <= tap_r + 1'b1;
            end else begin
              tap_c <= tap_c + 1'b1;
            end
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACCEPT;
            if (last_win) begin
              last_win   <= 1'b0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end
          end
        end

        default: state <= ST_ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_param.sv
// Bench for conv_layer_param: a STRIDE=1 and a STRIDE=2 instance, checked against a direct convolution model.
module tb_conv_layer_param;

  localparam int W = 28, H = 28, DB = 8, WB = 8, K = 7, NC = 3, AB = 23;
  localparam int TAPS = K * K, OWID = NC * AB, BUDGET = 40000;

  logic clk = 1'b0, rst = 1'b1, sel = 1'b0;
  logic [DB-1:0] in_data = '0;
  logic [WB-1:0] w_data = '0;
  logic in_valid = 1'b0, w_load = 1'b0, out_ready = 1'b0;

  logic in_ready1, out_valid1, frame_done1, busy1;
  logic in_ready2, out_valid2, frame_done2, busy2;
  logic [OWID-1:0] out_data1, out_data2;

  wire in_valid1 = in_valid & ~sel;
  wire in_valid2 = in_valid & sel;
  wire w_load1   = w_load & ~sel;
  wire w_load2   = w_load & sel;

  wire            cur_in_ready   = sel ? in_ready2   : in_ready1;
  wire            cur_out_valid  = sel ? out_valid2  : out_valid1;
  wire            cur_frame_done = sel ? frame_done2 : frame_done1;
  wire            cur_busy       = sel ? busy2       : busy1;
  wire [OWID-1:0] cur_out_data   = sel ? out_data2   : out_data1;

  int checks = 0, failures = 0, fd_count = 0;
  bit timed_out = 1'b0;
  int pix [H*W];
  int wt [NC][TAPS];
  logic [OWID-1:0] exp_q [$];
  logic [OWID-1:0] first_data, second_data;

  conv_layer_param #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .WEIGHT_BITS(WB), .FILTER_SIZE(K),
                     .STRIDE(1), .NUM_CH(NC)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid1), .in_ready(in_ready1),
    .w_load(w_load1), .w_data(w_data), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .frame_done(frame_done1), .busy(busy1));

  conv_layer_param #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .WEIGHT_BITS(WB), .FILTER_SIZE(K),
                     .STRIDE(2), .NUM_CH(NC)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid2), .in_ready(in_ready2),
    .w_load(w_load2), .w_data(w_data), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready), .frame_done(frame_done2), .busy(busy2));

  // Clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (cur_frame_done === 1'b1) fd_count++;

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0; w_load = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Stimulus setup and reference model
  task automatic set_ramp();
    for (int i = 0; i < H*W; i++) pix[i] = i % 256;
  endtask

  task automatic set_weights(input int v0, input int v1, input int v2);
    for (int t = 0; t < TAPS; t++) begin
      wt[0][t] = v0; wt[1][t] = v1; wt[2][t] = v2;
    end
  endtask

  task automatic load_weights();
    @(negedge clk);
    for (int ch = 0; ch < NC; ch++)
      for (int t = 0; t < TAPS; t++) begin
        w_load = 1'b1;
        w_data = wt[ch][t][WB-1:0];
        @(negedge clk);
      end
    w_load = 1'b0;
  endtask

  task automatic build_expected(input int stride, input int max_trig);
    int ow, oh, trig_idx, acc;
    logic [OWID-1:0] v;
    exp_q.delete();
    ow = (W - K) / stride + 1;
    oh = (H - K) / stride + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        trig_idx = (oy*stride + K - 1) * W + ox*stride + K - 1;
        if (trig_idx <= max_trig) begin
          for (int ch = 0; ch < NC; ch++) begin
            acc = 0;
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++)
                acc += pix[(oy*stride + ky) * W + ox*stride + kx] * wt[ch][ky*K + kx];
`ifdef CONV_RELU_EN
            if (acc < 0) acc = 0;
`endif
            v[ch*AB +: AB] = acc[AB-1:0];
          end
          exp_q.push_back(v);
        end
      end
  endtask

  // Driver + scoreboard: feeds n_pix pixels, drains and checks the expected queue.
  task automatic run_frame(input int n_pix, input int vrate, input int rrate, input int hold,
                           input bit spam, input bit full);
    int n_out, fd0, got;
    n_out = exp_q.size();
    fd0 = fd_count;
    got = 0;
    @(negedge clk);
    fork
      begin : drive
        for (int i = 0; i < n_pix && !timed_out; i++) begin
          bit acc_now;
          int wc;
          while ($urandom_range(99) >= vrate) @(negedge clk);
          in_valid = 1'b1;
          in_data = pix[i][DB-1:0];
          acc_now = 1'b0;
          wc = 0;
          while (!acc_now && !timed_out) begin
            acc_now = cur_in_ready;
            @(negedge clk);
            if (!acc_now && ++wc > BUDGET) begin
              $display("FAIL pixel_accept_timeout: pixel %0d never accepted", i);
              failures++; timed_out = 1'b1;
            end
          end
          in_valid = 1'b0;
          if (spam && i == 0) begin w_load = 1'b1; w_data = 8'd5; end
        end
        w_load = 1'b0;
      end
      begin : monitor
        int cyc, hold_left;
        bit snap_ok, rdy;
        logic [OWID-1:0] snap, exp_v;
        cyc = 0; hold_left = hold; snap_ok = 1'b0;
        while (got < n_out && !timed_out) begin
          rdy = ($urandom_range(99) < rrate);
          if (cur_out_valid && got == 0 && hold_left > 0) begin
            rdy = 1'b0;
            if (!snap_ok) begin
              snap = cur_out_data; snap_ok = 1'b1;
            end else begin
              checks++;
              if (cur_out_data !== snap) begin
                $display("FAIL hold_stable: got %0h required %0h", cur_out_data, snap);
                failures++;
              end
            end
            checks++;
            if (cur_in_ready !== 1'b0) begin
              $display("FAIL hold_in_ready: got %b required 0", cur_in_ready);
              failures++;
            end
            hold_left--;
          end
          out_ready = rdy;
          if (cur_out_valid && rdy) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (cur_out_data !== exp_v) begin
              $display("FAIL out_data[%0d]: got %0h required %0h", got, cur_out_data, exp_v);
              failures++;
            end
            if (got == 0) first_data = cur_out_data;
            if (got == 1) second_data = cur_out_data;
            got++;
          end
          @(negedge clk);
          if (++cyc > BUDGET) begin
            $display("FAIL output_timeout: got %0d outputs required %0d", got, n_out);
            failures++; timed_out = 1'b1;
          end
        end
        out_ready = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    checks++;
    if (got !== n_out) begin
      $display("FAIL out_count: got %0d required %0d", got, n_out);
      failures++;
    end
    if (full) begin
      checks++;
      if (fd_count - fd0 !== 1) begin
        $display("FAIL frame_done_count: got %0d required 1", fd_count - fd0);
        failures++;
      end
      checks++;
      if (cur_busy !== 1'b0) begin
        $display("FAIL busy_after_frame: got %b required 0", cur_busy);
        failures++;
      end
    end
  endtask

  task automatic check_field(input string name, input logic [OWID-1:0] data, input int ch,
                             input logic [AB-1:0] req);
    checks++;
    if (data[ch*AB +: AB] !== req) begin
      $display("FAIL %s ch%0d: got %0h required %0h", name, ch, data[ch*AB +: AB], req);
      failures++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 10;
    if (in_ready1 !== 1'b1 || in_ready2 !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b/%b required 1/1", in_ready1, in_ready2); failures++;
    end
    if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b/%b required 0/0", out_valid1, out_valid2); failures++;
    end
    if (out_data1 !== '0 || out_data2 !== '0) begin
      $display("FAIL reset_out_data: got %0h/%0h required 0/0", out_data1, out_data2); failures++;
    end
    if (frame_done1 !== 1'b0 || frame_done2 !== 1'b0) begin
      $display("FAIL reset_frame_done: got %b/%b required 0/0", frame_done1, frame_done2); failures++;
    end
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      $display("FAIL reset_busy: got %b/%b required 0/0", busy1, busy2); failures++;
    end
  endtask

  // All +1 weights, ramp frame, first output held 20 cycles, w_load=5 spammed while busy.
  task automatic test_ramp_stride1();
    sel = 1'b0;
    set_weights(1, 1, 1);
    load_weights();
    set_ramp();
    build_expected(1, H*W);
    run_frame(H*W, 100, 100, 20, 1'b1, 1'b1);
    for (int ch = 0; ch < NC; ch++) check_field("first_out_s1", first_data, ch, 23'd4263);
  endtask

  // Loaded after the previous frame_done: channel 1 inverted.
  task automatic test_neg_relu();
    logic [AB-1:0] req1;
`ifdef CONV_RELU_EN
    req1 = '0;
`else
    req1 = 23'h7FEF59;
`endif
    sel = 1'b0;
    set_weights(1, -1, 1);
    load_weights();
    set_ramp();
    build_expected(1, K*W - 1 - (W - K));
    run_frame(K*W - (W - K), 100, 100, 0, 1'b0, 1'b0);
    check_field("neg_first", first_data, 0, 23'd4263);
    check_field("neg_first", first_data, 1, req1);
    check_field("neg_first", first_data, 2, 23'd4263);
    pulse_reset();
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0;
    set_weights(1, 1, 1);
    load_weights();
    set_ramp();
    build_expected(1, 299);
    run_frame(300, 100, 100, 0, 1'b0, 1'b0);
    checks++;
    if (busy1 !== 1'b1) begin
      $display("FAIL busy_mid_frame: got %b required 1", busy1); failures++;
    end
    pulse_reset();
    checks++;
    if (busy1 !== 1'b0 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      $display("FAIL mid_reset_state: got busy=%b in_ready=%b out_valid=%b required 0/1/0",
               busy1, in_ready1, out_valid1);
      failures++;
    end
    build_expected(1, H*W);
    run_frame(H*W, 80, 90, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stride2();
    sel = 1'b1;
    set_weights(1, 1, 1);
    load_weights();
    set_ramp();
    build_expected(2, H*W);
    run_frame(H*W, 100, 100, 0, 1'b0, 1'b1);
    for (int ch = 0; ch < NC; ch++) begin
      check_field("first_out_s2", first_data, ch, 23'd4263);
      check_field("second_out_s2", second_data, ch, 23'd4361);
    end
  endtask

  // Random weights/pixels and random valid/ready, straight after the previous frame.
  task automatic test_back_to_back_random();
    int r;
    sel = 1'b1;
    for (int ch = 0; ch < NC; ch++)
      for (int t = 0; t < TAPS; t++) begin
        r = $urandom_range(255);
        wt[ch][t] = (r > 127) ? r - 256 : r;
      end
    for (int i = 0; i < H*W; i++) pix[i] = $urandom_range(255);
    load_weights();
    build_expected(2, H*W);
    run_frame(H*W, 70, 60, 0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_ramp_stride1();
    test_neg_relu();
    test_reset_mid_frame();
    test_stride2();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
